vertex_projector: RTL and testbench

VERTEX_PROJECTOR -- requirements
Module: vertex_projector

---
 rtl/vertex_projector_pkg.sv | 40 ++++
 rtl/vertex_projector_trig.sv | 30 +++
 rtl/vertex_projector.sv | 161 ++++++++++++++++
 tb/tb_vertex_projector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vertex_projector_pkg.sv
// Shared graphics types for the vertex projection pipeline.
package vertex_projector_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    // Fractional bits of the Q1.7 sine/cosine values.
    localparam int TRIG_FRAC = 7;

    typedef struct packed {
        logic signed [9:0] x;
        logic signed [9:0] y;
        logic signed [9:0] z;
    } vertex_3d_t;

    typedef struct packed {
        logic        [9:0] x;
        logic        [9:0] y;
        logic signed [9:0] z;
    } vertex_2d_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRotate,
        StStore,
        StSwap
    } proj_state_t;

    // Clamp a signed screen coordinate into 0..hi.
    function automatic logic [9:0] clamp_coord(input logic signed [13:0] v, input int hi);
        if (v < 0) begin
            return '0;
        end
        if (int'(v) > hi) begin
            return 10'(hi);
        end
        return v[9:0];
    endfunction

endpackage

// File: rtl/vertex_projector_trig.sv
// Combinational Q1.7 sine/cosine lookup; 256 angle units per full turn.
module trig_lut (
    input  logic        [7:0] i_angle,
    output logic signed [8:0] o_sin,
    output logic signed [8:0] o_cos
);

    // round(128 * sin(k * 2pi / 256)) for the first quadrant, k = 0..64.
    localparam logic [7:0] QSIN [65] = '{
          0,   3,   6,   9,  13,  16,  19,  22,  25,  28,  31,  34,  37,  40,  43,  46,
         49,  52,  55,  58,  60,  63,  66,  68,  71,  74,  76,  79,  81,  84,  86,  88,
         91,  93,  95,  97,  99, 101, 103, 105, 106, 108, 110, 111, 113, 114, 116, 117,
        118, 119, 121, 122, 122, 123, 124, 125, 126, 126, 127, 127, 127, 128, 128, 128,
        128
    };

    // Fold the angle into the first quadrant and restore the sign.
    function automatic logic signed [8:0] sin_q(input logic [7:0] a);
        logic [6:0] r;
        r = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        return a[7] ? -$signed({1'b0, QSIN[r]}) : $signed({1'b0, QSIN[r]});
    endfunction

    // cos(a) is sin(a + quarter turn).
    always_comb begin
        o_sin = sin_q(i_angle);
        o_cos = sin_q(i_angle + 8'd64);
    end

endmodule

// File: rtl/vertex_projector.sv
// Per-frame Y-axis rotation and screen projection of a small vertex set.
// Results are built in a shadow buffer and published in a single cycle.
module vertex_projector
    import vertex_projector_pkg::*;
#(
    parameter int NUM_VERTS = 8,
    parameter int CENTER_X  = 320,
    parameter int CENTER_Y  = 240
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame,
    input  logic       i_enable,
    input  logic [7:0] i_angle_step,
    input  vertex_3d_t i_vertices_3d [NUM_VERTS],
    output vertex_2d_t o_vertices_2d [NUM_VERTS],
    output logic       o_busy,
    output logic       o_done,
    output logic       o_overrun
);

    localparam int IdxW = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VERTS - 1);
    localparam vertex_2d_t CenterVtx = '{x: 10'(CENTER_X), y: 10'(CENTER_Y), z: 10'd0};

    proj_state_t       r_state, w_state_d;
    logic [IdxW-1:0]   r_idx;
    logic [7:0]        r_angle;
    logic signed [9:0] r_vx, r_vy, r_vz;
    logic signed [8:0] r_sin, r_cos;
    logic signed [12:0] r_xr, r_zr;
    logic signed [9:0] r_yr;
    logic              r_done, r_overrun;
    vertex_2d_t        r_shadow   [NUM_VERTS];
    vertex_2d_t        r_vertices [NUM_VERTS];

    logic signed [8:0]  w_sin, w_cos;
    logic signed [18:0] w_xc, w_zs, w_zc, w_xs;
    logic signed [19:0] w_xsum, w_zsum;
    logic signed [13:0] w_sx, w_sy;
    vertex_2d_t         w_store;

    trig_lut u_trig (
        .i_angle (r_angle),
        .o_sin   (w_sin),
        .o_cos   (w_cos)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_d = r_state;
        o_busy    = (r_state != StIdle);
        case (r_state)
            StIdle:   if (i_frame) w_state_d = StLoad;
            StLoad:   w_state_d = StRotate;
            StRotate: w_state_d = StStore;
            StStore:  w_state_d = (r_idx == LastIdx) ? StSwap : StLoad;
            StSwap:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Rotation about Y and projection to screen space, with clamping.
    always_comb begin
        w_xc   = 19'(r_vx) * 19'(r_cos);
        w_zs   = 19'(r_vz) * 19'(r_sin);
        w_zc   = 19'(r_vz) * 19'(r_cos);
        w_xs   = 19'(r_vx) * 19'(r_sin);
        w_xsum = 20'(w_xc) + 20'(w_zs);
        w_zsum = 20'(w_zc) - 20'(w_xs);
        w_sx   = 14'(CENTER_X) + 14'(r_xr);
        w_sy   = 14'(CENTER_Y) - 14'(r_yr);
        w_store.x = clamp_coord(w_sx, SCREEN_W - 1);
        w_store.y = clamp_coord(w_sy, SCREEN_H - 1);
        if (r_zr > 13'sd511) begin
            w_store.z = 10'h1FF;
        end else if (r_zr < -13'sd512) begin
            w_store.z = 10'h200;
        end else begin
            w_store.z = r_zr[9:0];
        end
    end

    // Pass control, per-vertex operand capture and pulse outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx     <= '0;
            r_angle   <= '0;
            r_vx      <= '0;
            r_vy      <= '0;
            r_vz      <= '0;
            r_sin     <= '0;
            r_cos     <= '0;
            r_xr      <= '0;
            r_yr      <= '0;
            r_zr      <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= (r_state == StSwap);
            // A frame during any non-idle state, SWAP included, is dropped.
            r_overrun <= i_frame && (r_state != StIdle);
            case (r_state)
                StIdle: begin
                    if (i_frame) begin
                        if (i_enable) r_angle <= r_angle + i_angle_step;
                        r_idx <= '0;
                    end
                end
                StLoad: begin
                    r_vx  <= i_vertices_3d[r_idx].x;
                    r_vy  <= i_vertices_3d[r_idx].y;
                    r_vz  <= i_vertices_3d[r_idx].z;
                    r_sin <= w_sin;
                    r_cos <= w_cos;
                end
                StRotate: begin
                    r_xr <= 13'(w_xsum >>> TRIG_FRAC);
                    r_yr <= r_vy;
                    r_zr <= 13'(w_zsum >>> TRIG_FRAC);
                end
                StStore: begin
                    if (r_idx != LastIdx) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shadow buffer written one vertex per STORE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_VERTS; i++) r_shadow[i] <= CenterVtx;
        end else if (r_state == StStore) begin
            r_shadow[r_idx] <= w_store;
        end
    end

    // Visible buffer updated atomically so the rasterizer never sees a mix.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_VERTS; i++) r_vertices[i] <= CenterVtx;
        end else if (r_state == StSwap) begin
            r_vertices <= r_shadow;
        end
    end

    assign o_vertices_2d = r_vertices;
    assign o_done        = r_done;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_vertex_projector.sv
// Directed and randomised checks of vertex_projector against a real-valued model.
module tb_vertex_projector;
    import vertex_projector_pkg::*;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame;
    logic       enable;
    logic [7:0] angle_step;
    vertex_3d_t vin  [N];
    vertex_3d_t vnext[N];
    vertex_3d_t vold [N];
    vertex_3d_t vexp [N];
    vertex_2d_t vout [N];
    vertex_2d_t prev [N];
    logic       busy, done, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int illegal = 0;
    int tb_angle = 0;
    int lat, n_ovr, n_busy, n_done;

    vertex_projector #(
        .NUM_VERTS (N),
        .CENTER_X  (320),
        .CENTER_Y  (240)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame       (frame),
        .i_enable      (enable),
        .i_angle_step  (angle_step),
        .i_vertices_3d (vin),
        .o_vertices_2d (vout),
        .o_busy        (busy),
        .o_done        (done),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; also flag any output change outside a done cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rst && !done && vout[i] !== prev[i]) illegal++;
            prev[i] = vout[i];
        end
    endtask

    function automatic int msin(input int a);
        real r;
        r = 128.0 * $sin(2.0 * 3.14159265358979 * real'(a % 256) / 256.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic vertex_3d_t v3(input int x, input int y, input int z);
        vertex_3d_t v;
        v.x = 10'(x);
        v.y = 10'(y);
        v.z = 10'(z);
        return v;
    endfunction

    task automatic check_all(input string tag, input vertex_3d_t src [N], input int ang);
        int s, c, x, y, z, xp, zp, ox, oy, oz;
        s = msin(ang);
        c = msin(ang + 64);
        for (int i = 0; i < N; i++) begin
            x  = src[i].x;
            y  = src[i].y;
            z  = src[i].z;
            xp = (x * c + z * s) >>> 7;
            zp = (z * c - x * s) >>> 7;
            ox = vout[i].x;
            oy = vout[i].y;
            oz = vout[i].z;
            chk($sformatf("%s_v%0d_x", tag, i), ox, clampi(320 + xp, 0, 639));
            chk($sformatf("%s_v%0d_y", tag, i), oy, clampi(240 - y, 0, 479));
            chk($sformatf("%s_v%0d_z", tag, i), oz, clampi(zp, -512, 511));
        end
    endtask

    // Pulse frame, then run until done (bounded). Optional extra frame and input change.
    task automatic run_pass(input int ovr_at, input int chg_at,
                            output int l, output int no, output int nb);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        l = 0;
        no = 0;
        nb = 0;
        for (int c = 1; c <= 40; c++) begin
            if (overrun) no++;
            if (busy) nb++;
            if (done) begin
                l = c;
                break;
            end
            if (c == ovr_at) frame = 1'b1;
            if (c == chg_at) vin = vnext;
            tick();
            frame = 1'b0;
        end
        tick();
    endtask

    task automatic pass_and_check(input string tag);
        if (enable) tb_angle = (tb_angle + int'(angle_step)) % 256;
        run_pass(0, 0, lat, n_ovr, n_busy);
        chk({tag, "_latency"}, lat, 26);
        check_all(tag, vin, tb_angle);
    endtask

    initial begin
        rst = 1'b1;
        frame = 1'b0;
        enable = 1'b0;
        angle_step = 8'd0;
        for (int i = 0; i < N; i++) vin[i] = v3(i * 37 - 100, 60 - i * 25, i * 20 - 70);
        vin[0] = v3(100, 50, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state.
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_v0_x", int'(vout[0].x), 320);
        chk("rst_v0_y", int'(vout[0].y), 240);
        chk("rst_v7_z", int'(vout[N-1].z), 0);

        // Static pass at angle 0.
        run_pass(0, 0, lat, n_ovr, n_busy);
        chk("basic_latency", lat, 26);
        chk("basic_busy_cycles", n_busy, 25);
        chk("basic_overrun", n_ovr, 0);
        chk("basic_v0_x", int'(vout[0].x), 420);
        chk("basic_v0_y", int'(vout[0].y), 190);
        chk("basic_v0_z", int'(vout[0].z), 0);
        check_all("basic", vin, 0);

        // Quarter turn.
        enable = 1'b1;
        angle_step = 8'd64;
        vin[0] = v3(100, 0, 0);
        pass_and_check("quarter");
        chk("quarter_v0_x", int'(vout[0].x), 320);
        chk("quarter_v0_z", int'(vout[0].z), -100);

        // Angle wraps 64 + 192 -> 0; clamp at both screen edges.
        angle_step = 8'd192;
        vin[0] = v3(511, -511, 0);
        vin[1] = v3(-512, 511, 0);
        pass_and_check("clamp");
        chk("clamp_v0_x", int'(vout[0].x), 639);
        chk("clamp_v0_y", int'(vout[0].y), 479);
        chk("clamp_v1_x", int'(vout[1].x), 0);
        chk("clamp_v1_y", int'(vout[1].y), 0);

        // Zero step with enable high.
        angle_step = 8'd0;
        pass_and_check("zero_step");

        // Extra frame five cycles into a pass.
        angle_step = 8'd64;
        vin[0] = v3(100, 0, 0);
        tb_angle = 64;
        run_pass(5, 0, lat, n_ovr, n_busy);
        chk("ovr5_latency", lat, 26);
        chk("ovr5_pulses", n_ovr, 1);
        check_all("ovr5", vin, tb_angle);

        // Extra frame in the SWAP cycle, then a frame right after done.
        angle_step = 8'd10;
        tb_angle = 74;
        run_pass(25, 0, lat, n_ovr, n_busy);
        chk("ovr_swap_latency", lat, 26);
        chk("ovr_swap_pulses", n_ovr, 1);
        check_all("ovr_swap", vin, tb_angle);
        pass_and_check("back_to_back");

        // Inputs changed mid-pass: vertices 0 and 1 already loaded by cycle 5.
        enable = 1'b0;
        vold = vin;
        for (int i = 0; i < N; i++) vnext[i] = v3(200 - i * 41, i * 30 - 90, 150 - i * 13);
        run_pass(0, 5, lat, n_ovr, n_busy);
        chk("midchg_latency", lat, 26);
        for (int i = 0; i < N; i++) vexp[i] = (i < 2) ? vold[i] : vnext[i];
        check_all("midchg", vexp, tb_angle);

        // Reset in cycle 10 of a pass.
        enable = 1'b1;
        angle_step = 8'd30;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_v0_x", int'(vout[0].x), 320);
        chk("abort_v0_y", int'(vout[0].y), 240);
        chk("abort_v5_z", int'(vout[5].z), 0);
        tick();
        tick();
        rst = 1'b0;
        n_done = 0;
        repeat (30) begin
            tick();
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        tb_angle = 0;
        pass_and_check("after_abort");

        // Random frames against the model.
        for (int f = 0; f < 100; f++) begin
            enable = 1'($urandom_range(0, 1));
            angle_step = 8'($urandom);
            for (int i = 0; i < N; i++) begin
                vin[i] = v3($urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512,
                            $urandom_range(0, 1023) - 512);
            end
            pass_and_check($sformatf("rnd%0d", f));
        end

        chk("hold_between_done", illegal, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
